// File: rtl/btb_pkg.sv
// btb_pkg: shared types and constants for the fetch-side branch target buffer.
//   N_WAYS / WAY_W  : associativity and way-index width
//   ctr_t           : 2-bit saturating direction counter encoding
//   plru_t          : 3-bit tree PLRU state {b2, b1, b0}, b0 is the root
//   btb_entry_t     : one BTB entry (valid, tag, target, counter)
package btb_pkg;

  localparam int unsigned N_WAYS     = 4;
  localparam int unsigned WAY_W      = 2;
  // Entry fields are sized for the widest supported PC; narrower configurations
  // zero-extend into them.
  localparam int unsigned MAX_ADDR_W = 64;

  typedef logic [WAY_W-1:0]      way_t;
  typedef logic [MAX_ADDR_W-1:0] addr_max_t;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_SNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // bit 0 = root (b0), bit 1 = ways 0/1 (b1), bit 2 = ways 2/3 (b2)
  typedef logic [2:0] plru_t;

  typedef struct packed {
    logic      valid;
    addr_max_t tag;
    addr_max_t target;
    ctr_t      ctr;
  } btb_entry_t;

  // Saturating counter step: up on taken, down on not taken, no wrap.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != CTR_ST) n = ctr_t'(c + 2'd1);
    end else begin
      if (c != CTR_SNT) n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// btb_predictor_if: prediction and resolution bundle between fetch/execute and
// the BTB predictor.
//   master : pipeline side, drives the lookup PC and the resolution fields
//   slave  : predictor side, returns taken/target/way for the lookup PC
interface btb_predictor_if
  import btb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64
) ();

  // lookup
  logic [ADDR_WIDTH-1:0] i_pc;
  logic                  o_branch_pred_taken;
  logic [ADDR_WIDTH-1:0] o_pc_target_pred;
  logic [WAY_W-1:0]      o_btb_way;

  // resolution
  logic                  i_branch_exec;
  logic                  i_branch_taken_exec;
  logic [WAY_W-1:0]      i_btb_way_exec;
  logic [ADDR_WIDTH-1:0] i_pc_exec;
  logic [ADDR_WIDTH-1:0] i_pc_target_exec;
  logic                  i_stall_exec;

  modport master (
    output i_pc, i_branch_exec, i_branch_taken_exec, i_btb_way_exec,
           i_pc_exec, i_pc_target_exec, i_stall_exec,
    input  o_branch_pred_taken, o_pc_target_pred, o_btb_way
  );

  modport slave (
    input  i_pc, i_branch_exec, i_branch_taken_exec, i_btb_way_exec,
           i_pc_exec, i_pc_target_exec, i_stall_exec,
    output o_branch_pred_taken, o_pc_target_pred, o_btb_way
  );

endinterface

// File: rtl/btb_plru.sv
// btb_plru: combinational 4-way tree pseudo-LRU helper.
//   plru      in  current PLRU bits of the set
//   valid     in  per-way valid vector of the set
//   touch_way in  way being touched
//   victim    out lowest invalid way, else the tree victim
//   plru_next out PLRU bits after touching touch_way
module btb_plru
  import btb_pkg::*;
(
  input  plru_t             plru,
  input  logic [N_WAYS-1:0] valid,
  input  way_t              touch_way,
  output way_t              victim,
  output plru_t             plru_next
);

  always_comb begin
    victim = plru[0] ? {1'b1, plru[2]} : {1'b0, plru[1]};
    // Scan from the top so the lowest-index invalid way wins.
    for (int unsigned w = N_WAYS; w > 0; w--) begin
      if (!valid[way_t'(w - 1)]) victim = way_t'(w - 1);
    end
  end

  always_comb begin
    plru_next = plru;
    if (!touch_way[1]) begin
      plru_next[0] = 1'b1;
      plru_next[1] = ~touch_way[0];
    end else begin
      plru_next[0] = 1'b0;
      plru_next[2] = ~touch_way[0];
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: 4-way set-associative, flop-based branch target buffer with
// 2-bit saturating direction counters and a 3-bit tree PLRU per set.
//   i_clk   in  clock
//   i_arst  in  synchronous active-high reset; clears all state
//   bus     slave modport of btb_predictor_if:
//           i_pc -> o_branch_pred_taken / o_pc_target_pred / o_btb_way (same cycle)
//           i_branch_exec, i_branch_taken_exec, i_btb_way_exec, i_pc_exec,
//           i_pc_target_exec, i_stall_exec -> update written at the next edge
module btb_predictor
  import btb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SET_COUNT  = 16
) (
  input  logic           i_clk,
  input  logic           i_arst,
  btb_predictor_if.slave bus
);

  localparam int unsigned INDEX_W = $clog2(SET_COUNT);
  localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_W - 2;

  typedef logic [INDEX_W-1:0] set_t;
  typedef logic [TAG_W-1:0]   tag_t;

  btb_entry_t entries [SET_COUNT][N_WAYS];
  plru_t      plru_q  [SET_COUNT];

  // ---------------------------------------------------------------- lookup
  set_t              lk_set;
  tag_t              lk_tag;
  logic [N_WAYS-1:0] lk_valid;
  logic [N_WAYS-1:0] lk_hit;
  way_t              lk_hit_way;
  addr_max_t         lk_target;
  ctr_t              lk_ctr;
  way_t              lk_victim;
  plru_t             unused_lk_next;

  assign lk_set = bus.i_pc[INDEX_W+1:2];
  assign lk_tag = bus.i_pc[ADDR_WIDTH-1:INDEX_W+2];

  always_comb begin
    lk_valid   = '0;
    lk_hit     = '0;
    lk_hit_way = '0;
    lk_target  = '0;
    lk_ctr     = CTR_RESET;
    for (int unsigned w = 0; w < N_WAYS; w++) begin
      lk_valid[way_t'(w)] = entries[lk_set][way_t'(w)].valid;
      lk_hit[way_t'(w)]   = entries[lk_set][way_t'(w)].valid &&
                            (entries[lk_set][way_t'(w)].tag == addr_max_t'(lk_tag));
      // Tags within a set are unique, so at most one way takes this branch.
      if (lk_hit[way_t'(w)]) begin
        lk_hit_way = way_t'(w);
        lk_target  = entries[lk_set][way_t'(w)].target;
        lk_ctr     = entries[lk_set][way_t'(w)].ctr;
      end
    end
  end

  btb_plru u_plru_lookup (
    .plru      (plru_q[lk_set]),
    .valid     (lk_valid),
    .touch_way ('0),
    .victim    (lk_victim),
    .plru_next (unused_lk_next)
  );

  assign bus.o_branch_pred_taken = (|lk_hit) & lk_ctr[1];
  assign bus.o_pc_target_pred    = ADDR_WIDTH'(lk_target);
  assign bus.o_btb_way           = (|lk_hit) ? lk_hit_way : lk_victim;

  // ---------------------------------------------------------------- update
  logic       up_en;
  logic       up_taken;
  set_t       up_set;
  tag_t       up_tag;
  way_t       up_way;
  btb_entry_t up_cur;
  logic       up_match;
  btb_entry_t up_entry;
  logic       up_write;
  plru_t      up_plru_next;
  way_t       unused_up_victim;

  assign up_en    = bus.i_branch_exec & ~bus.i_stall_exec;
  assign up_taken = bus.i_branch_taken_exec;
  assign up_set   = bus.i_pc_exec[INDEX_W+1:2];
  assign up_tag   = bus.i_pc_exec[ADDR_WIDTH-1:INDEX_W+2];
  assign up_way   = bus.i_btb_way_exec;
  assign up_cur   = entries[up_set][up_way];
  assign up_match = up_cur.valid && (up_cur.tag == addr_max_t'(up_tag));

  always_comb begin
    up_entry = up_cur;
    up_write = 1'b0;
    if (up_en) begin
      if (up_match) begin
        up_write     = 1'b1;
        up_entry.ctr = ctr_next(up_cur.ctr, up_taken);
        if (up_taken) up_entry.target = addr_max_t'(bus.i_pc_target_exec);
      end else if (up_taken) begin
        up_write        = 1'b1;
        up_entry.valid  = 1'b1;
        up_entry.tag    = addr_max_t'(up_tag);
        up_entry.target = addr_max_t'(bus.i_pc_target_exec);
        up_entry.ctr    = CTR_ALLOC;
      end
    end
  end

  btb_plru u_plru_update (
    .plru      (plru_q[up_set]),
    .valid     ('1),
    .touch_way (up_way),
    .victim    (unused_up_victim),
    .plru_next (up_plru_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      for (int unsigned s = 0; s < SET_COUNT; s++) begin
        plru_q[set_t'(s)] <= '0;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
          entries[set_t'(s)][way_t'(w)] <= '0;
        end
      end
    end else if (up_write) begin
      entries[up_set][up_way] <= up_entry;
      plru_q[up_set]          <= up_plru_next;
    end
  end

  // PC byte-offset bits and the unused halves of the PLRU helpers.
  logic unused_bits;
  assign unused_bits = ^{bus.i_pc[1:0], bus.i_pc_exec[1:0], unused_lk_next, unused_up_victim};

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Fetch-side branch target buffer and direction predictor, the producer of the prediction fields that the execute stage checks and the consumer of the resolution fields it reports back. Each cycle it looks up the fetch PC and returns a taken prediction, a predicted target and the BTB way used. When a branch or jump resolves in execute, it updates that entry's 2-bit saturating counter, target and pseudo-LRU state, or allocates a new entry. Storage is 4-way set-associative, flop-based, with a 3-bit tree PLRU per set.

## Interface
- ADDR_WIDTH, 64, PC and target width
- SET_COUNT, 16, sets per way; power of two, at least 2; INDEX_W = log2(SET_COUNT)
- i_clk  in  1  clock
- i_arst  in  1  reset, synchronous, active-high
- i_pc  in  ADDR_WIDTH  fetch PC to look up
- o_branch_pred_taken  out  1  predicted taken
- o_pc_target_pred  out  ADDR_WIDTH  predicted target; 0 on miss
- o_btb_way  out  2  hit way on hit, victim way on miss
- i_branch_exec  in  1  branch or jump resolved in execute
- i_branch_taken_exec  in  1  resolved direction
- i_btb_way_exec  in  2  way carried down the pipe from prediction time
- i_pc_exec  in  ADDR_WIDTH  PC of the resolved instruction
- i_pc_target_exec  in  ADDR_WIDTH  resolved target
- i_stall_exec  in  1  execute stage stalled; update suppressed

## Operation
- Address split:
  - Set index = pc[INDEX_W+1:2].
  - Tag = pc[ADDR_WIDTH-1:INDEX_W+2].
  - pc[1:0] is ignored.
- Per entry: valid, tag, target, 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup is combinational from the stored arrays.
  - Hit: the entry is valid and its tag matches. Tags in a set are unique, so at most one way hits.
  - o_branch_pred_taken = hit & counter[1].
  - o_pc_target_pred = the hit entry's target, or 0 on miss.
  - o_btb_way = the hit way. On miss it is the lowest-index invalid way, or the PLRU victim if all four ways are valid.
- Update happens on i_branch_exec & ~i_stall_exec. Let S be the set and W = i_btb_way_exec.
  - Match (S,W) valid with tag equal to the tag of i_pc_exec:
    - Counter saturating +1 if taken, -1 if not taken.
    - Target <= i_pc_target_exec if taken.
    - PLRU touched with W.
  - No match and taken: allocate (S,W) with valid=1, the new tag and target, counter=10, and touch the PLRU with W.
  - No match and not taken: no state change.
- PLRU per set, bits b0 (root), b1 (ways 0/1), b2 (ways 2/3):
  - Victim: if b0=0, the way selected by b1 (0 gives way 0, 1 gives way 1). If b0=1, the way selected by b2 (0 gives way 2, 1 gives way 3).
  - Touch way w in {0,1}: b0<=1, b1<=~w[0].
  - Touch way w in {2,3}: b0<=0, b2<=~w[0].
- Lookups do not modify the PLRU. Only updates do.
- No bypass: a lookup in the same cycle as an update to the same set sees pre-update state.

## Timing
- Lookup latency 0: outputs are valid in the same cycle as i_pc.
- Update latency 1: the write happens at the rising edge, and a lookup in the following cycle sees it.
- Exactly one update per resolved instruction. Cycles with i_stall_exec=1 perform no write, however long the stall lasts.
- Reset: while i_arst=1 at an edge, all valid bits, counters, tags, targets and PLRU bits are cleared to 0, and a coincident update is discarded.
  - After reset, outputs for any PC: o_branch_pred_taken=0, o_pc_target_pred=0, o_btb_way=0.
  - A reset mid-stall or mid-stream behaves identically.
- Counter saturates at 11 (taken) and 00 (not taken). There is no wrap.
- i_btb_way_exec is trusted as given; no re-lookup is performed at update.

## Structure
- Package btb_pkg holds:
  - N_WAYS=4 and WAY_W=2.
  - The counter encoding constants and the counter reset value.
  - The btb_entry_t struct (valid, tag, target, ctr).
  - plru_t (3 bits).
- Sub-module btb_plru: combinational PLRU, mapping (plru bits, valid vector) to victim way and (plru bits, touched way) to next plru. Instantiated once for lookup and once for update.
- The top module holds the entry arrays, the PLRU array, hit/compare logic and update logic.

## Test plan
- Reset, then i_pc=0x1000 -> taken=0, target=0, way=0.
- Update with pc_exec=0x1000, way 0, taken, target 0x2000; next cycle i_pc=0x1000 -> taken=1, target=0x2000, way=0 (counter 10).
- Two not-taken updates on 0x1000 -> after the first, taken=0 and the entry still hits on way 0; after the second the counter is 00. Then one taken update -> counter 01, taken=0.
- Allocate taken branches 0x1000, 0x2000, 0x3000, 0x4000 (all set 0) with ways 0,1,2,3 in that order; i_pc=0x5000 -> miss, way=0 (PLRU victim), taken=0.
- Hold pc_exec=0x1000 taken for 3 cycles with i_stall_exec=1,1,0 -> counter moves 10->11 exactly once.
- Same-cycle lookup of 0x1000 and first taken allocation of 0x1000 -> lookup taken=0, target=0; next cycle taken=1.
